// File: rtl/alu_pkg.sv
// alu_pkg: shared control codes, funct/ALUOp encodings and FSM state type for
// the multi-cycle ALU and its decoder.
package alu_pkg;

   // Control codes driven on ctrl_o
   localparam logic [2:0] CtrlAnd = 3'b000;
   localparam logic [2:0] CtrlOr  = 3'b001;
   localparam logic [2:0] CtrlAdd = 3'b010;
   localparam logic [2:0] CtrlSub = 3'b110;
   localparam logic [2:0] CtrlMul = 3'b011;
   localparam logic [2:0] CtrlSlt = 3'b111;
   localparam logic [2:0] CtrlDiv = 3'b100;

   // R-type funct encodings
   localparam logic [5:0] FunctAdd = 6'b100000;
   localparam logic [5:0] FunctSub = 6'b100010;
   localparam logic [5:0] FunctAnd = 6'b100100;
   localparam logic [5:0] FunctOr  = 6'b100101;
   localparam logic [5:0] FunctSlt = 6'b101010;
   localparam logic [5:0] FunctMul = 6'b011000;
   localparam logic [5:0] FunctDiv = 6'b011010;

   // ALUOp encodings
   localparam logic [1:0] AluOpAdd   = 2'b00;
   localparam logic [1:0] AluOpSub   = 2'b01;
   localparam logic [1:0] AluOpOr    = 2'b10;
   localparam logic [1:0] AluOpFunct = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDone
   } state_e;

endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational ALUOp/funct -> control code decoder. Also used by
// the hazard unit to predict multi-cycle ops. DIV is decoded only when
// ALU_MULTICYCLE_DIV_EN is defined.
module alu_decode
   import alu_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [5:0] funct_i,
   output logic [2:0] ctrl_o,
   output logic       illegal_o
);

   // Unknown funct falls back to the ADD code and raises illegal
   always_comb begin
      ctrl_o    = CtrlAdd;
      illegal_o = 1'b0;
      case (alu_op_i)
         AluOpAdd: ctrl_o = CtrlAdd;
         AluOpSub: ctrl_o = CtrlSub;
         AluOpOr:  ctrl_o = CtrlOr;
         default: begin
            case (funct_i)
               FunctAdd: ctrl_o = CtrlAdd;
               FunctSub: ctrl_o = CtrlSub;
               FunctAnd: ctrl_o = CtrlAnd;
               FunctOr:  ctrl_o = CtrlOr;
               FunctSlt: ctrl_o = CtrlSlt;
               FunctMul: ctrl_o = CtrlMul;
`ifdef ALU_MULTICYCLE_DIV_EN
               FunctDiv: ctrl_o = CtrlDiv;
`endif
               default:  illegal_o = 1'b1;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: EX-stage ALU. Single-cycle logic/arithmetic ops complete at
// the accept edge; MUL runs on an iterative shift-add engine retiring MUL_BITS
// multiplier bits per cycle. Defining ALU_MULTICYCLE_DIV_EN adds a signed
// restoring divider sharing the MUL state and counter.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MUL_BITS = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       alu_op_i,
   input  logic [5:0]       funct_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic [2:0]       ctrl_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             valid_o,
   output logic             busy_o,
   output logic             illegal_o
);

   localparam int unsigned     CntW   = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] MulCnt = CntW'(WIDTH / MUL_BITS);

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_load;
   logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q, valid_q, illegal_q;

   logic             dec_illegal, busy, accept, start_multi, last_step;
   logic [WIDTH-1:0] sc_result, mul_pp, mul_acc;
   logic [WIDTH-1:0] acc_step, mcand_step, mplier_step, fin_result;
   logic [WIDTH-1:0] mcand_load, mplier_load;

   alu_decode u_decode (
      .alu_op_i  (alu_op_i),
      .funct_i   (funct_i),
      .ctrl_o    (ctrl_o),
      .illegal_o (dec_illegal)
   );

   assign busy      = (state_q == StMul);
   assign accept    = start_i & ~busy;
   assign last_step = busy & (cnt_q == CntW'(1));

   // Single-cycle result; illegal ops produce zero even though ctrl reads ADD
   always_comb begin
      sc_result = '0;
      if (!dec_illegal) begin
         case (ctrl_o)
            CtrlAnd: sc_result = data1_i & data2_i;
            CtrlOr:  sc_result = data1_i | data2_i;
            CtrlAdd: sc_result = data1_i + data2_i;
            CtrlSub: sc_result = data1_i - data2_i;
            CtrlSlt: sc_result[0] = $signed(data1_i) < $signed(data2_i);
            default: sc_result = '0;
         endcase
      end
   end

   // Partial product of the next MUL_BITS multiplier bits
   always_comb begin
      mul_pp = '0;
      for (int i = 0; i < int'(MUL_BITS); i++) begin
         if (mplier_q[i]) mul_pp = mul_pp + (mcand_q << i);
      end
      mul_acc = acc_q + mul_pp;
   end

`ifdef ALU_MULTICYCLE_DIV_EN
   localparam logic [CntW-1:0] DivCnt = CntW'(WIDTH);

   logic             div_mode_q, neg_q, dz_q, start_div;
   logic [WIDTH:0]   rem_shift, rem_diff;
   logic [WIDTH-1:0] quo_step, quo_fix, abs_a, abs_b;

   assign start_div = ~dec_illegal & (ctrl_o == CtrlDiv);
   assign abs_a     = data1_i[WIDTH-1] ? -data1_i : data1_i;
   assign abs_b     = data2_i[WIDTH-1] ? -data2_i : data2_i;

   // Restoring step: remainder lives in acc_q, dividend/quotient in mplier_q
   always_comb begin
      rem_shift = {acc_q, mplier_q[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, mcand_q};
      quo_step  = {mplier_q[WIDTH-2:0], ~rem_diff[WIDTH]};
      quo_fix   = neg_q ? -quo_step : quo_step;
   end

   // Divider mode and sign/zero flags captured at every accept
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_mode_q <= 1'b0;
         neg_q      <= 1'b0;
         dz_q       <= 1'b0;
      end else if (accept) begin
         div_mode_q <= start_div;
         neg_q      <= data1_i[WIDTH-1] ^ data2_i[WIDTH-1];
         dz_q       <= (data2_i == '0);
      end
   end
`endif

   // Engine load values and per-cycle step, MUL by default
   always_comb begin
      start_multi = ~dec_illegal & (ctrl_o == CtrlMul);
      cnt_load    = MulCnt;
      mcand_load  = data1_i;
      mplier_load = data2_i;
      acc_step    = mul_acc;
      mcand_step  = mcand_q << MUL_BITS;
      mplier_step = mplier_q >> MUL_BITS;
      fin_result  = mul_acc;
`ifdef ALU_MULTICYCLE_DIV_EN
      if (start_div) begin
         start_multi = 1'b1;
         cnt_load    = DivCnt;
         mcand_load  = abs_b;
         mplier_load = abs_a;
      end
      if (div_mode_q) begin
         acc_step    = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
         mcand_step  = mcand_q;
         mplier_step = quo_step;
         fin_result  = dz_q ? '1 : quo_fix;
      end
`endif
   end

   // FSM next state: DONE behaves like IDLE for accepting a new op
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: state_d = (accept && start_multi) ? StMul : StIdle;
         StMul:          if (last_step) state_d = StDone;
         default:        state_d = StIdle;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Result, completion pulse and iterative engine registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         result_q  <= '0;
         zero_q    <= 1'b1;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (accept && start_multi) begin
            cnt_q    <= cnt_load;
            acc_q    <= '0;
            mcand_q  <= mcand_load;
            mplier_q <= mplier_load;
         end else if (accept) begin
            result_q  <= sc_result;
            zero_q    <= (sc_result == '0);
            illegal_q <= dec_illegal;
            valid_q   <= 1'b1;
         end else if (busy) begin
            cnt_q    <= cnt_q - CntW'(1);
            acc_q    <= acc_step;
            mcand_q  <= mcand_step;
            mplier_q <= mplier_step;
            if (last_step) begin
               result_q  <= fin_result;
               zero_q    <= (fin_result == '0);
               illegal_q <= 1'b0;
               valid_q   <= 1'b1;
            end
         end
      end
   end

   assign result_o  = result_q;
   assign zero_o    = zero_q;
   assign valid_o   = valid_q;
   assign busy_o    = busy;
   assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: table-driven and randomised checks of alu_multicycle
// (WIDTH=32/MUL_BITS=1 and WIDTH=16/MUL_BITS=4 instances) against a
// behavioural model. DIV expectations follow ALU_MULTICYCLE_DIV_EN.
module tb_alu_multicycle;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic [31:0] data1, data2;
   logic [2:0]  ctrl;
   logic [31:0] result;
   logic        zero, valid, busy, illegal;

   logic        s16;
   logic [1:0]  op16;
   logic [5:0]  fn16;
   logic [15:0] a16, b16;
   logic [2:0]  c16;
   logic [15:0] r16;
   logic        z16, v16, bz16, il16;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_multicycle #(.WIDTH(32), .MUL_BITS(1)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .alu_op_i(alu_op), .funct_i(funct),
      .data1_i(data1), .data2_i(data2), .ctrl_o(ctrl), .result_o(result), .zero_o(zero),
      .valid_o(valid), .busy_o(busy), .illegal_o(illegal)
   );

   alu_multicycle #(.WIDTH(16), .MUL_BITS(4)) dut16 (
      .clk_i(clk), .rst_i(rst), .start_i(s16), .alu_op_i(op16), .funct_i(fn16),
      .data1_i(a16), .data2_i(b16), .ctrl_o(c16), .result_o(r16), .zero_o(z16),
      .valid_o(v16), .busy_o(bz16), .illegal_o(il16)
   );

   typedef struct {
      logic [1:0]  op;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  ctrl;
      logic [31:0] res;
      logic        ill;
      int          lat;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model straight from the op definitions
   function automatic void model(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [2:0] c, output logic [31:0] r,
                                 output logic ill, output int lat);
      ill = 1'b0;
      lat = 1;
      c   = 3'b010;
      r   = 32'h0;
      case (op)
         2'b00: begin c = 3'b010; r = a + b; end
         2'b01: begin c = 3'b110; r = a - b; end
         2'b10: begin c = 3'b001; r = a | b; end
         default: begin
            case (fn)
               6'b100000: begin c = 3'b010; r = a + b; end
               6'b100010: begin c = 3'b110; r = a - b; end
               6'b100100: begin c = 3'b000; r = a & b; end
               6'b100101: begin c = 3'b001; r = a | b; end
               6'b101010: begin c = 3'b111; r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
               6'b011000: begin c = 3'b011; r = a * b; lat = 33; end
`ifdef ALU_MULTICYCLE_DIV_EN
               6'b011010: begin
                  c   = 3'b100;
                  lat = 33;
                  if (b == 32'h0) r = 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                  else r = $signed(a) / $signed(b);
               end
`endif
               default: begin c = 3'b010; r = 32'h0; ill = 1'b1; end
            endcase
         end
      endcase
   endfunction

   task automatic run_op(input string name, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [2:0] ectrl,
                         input logic [31:0] eres, input logic eill, input int elat);
      int k;
      int busy_cycles;
      alu_op = op;
      funct  = fn;
      data1  = a;
      data2  = b;
      start  = 1'b1;
      #1 check({name, "/ctrl"}, 32'(ctrl), 32'(ectrl));
      @(negedge clk);
      start = 1'b0;
      data1 = $urandom;
      data2 = $urandom;
      k = 1;
      busy_cycles = 0;
      while (!valid && k < elat + 4) begin
         if (busy) busy_cycles++;
         @(negedge clk);
         k++;
      end
      check({name, "/latency"}, 32'(k), 32'(elat));
      check({name, "/busy_cycles"}, 32'(busy_cycles), 32'(elat - 1));
      check({name, "/result"}, result, eres);
      check({name, "/zero"}, 32'(zero), 32'(eres == 32'h0));
      check({name, "/illegal"}, 32'(illegal), 32'(eill));
      @(negedge clk);
      check({name, "/valid_pulse"}, 32'(valid), 32'h0);
   endtask

   task automatic wait_valid(input int max, output int k);
      k = 1;
      while (!valid && k < max) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic run16(input string name, input logic [1:0] op, input logic [5:0] fn,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eres, input int elat);
      int k;
      op16 = op;
      fn16 = fn;
      a16  = a;
      b16  = b;
      s16  = 1'b1;
      @(negedge clk);
      s16 = 1'b0;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      k = 1;
      while (!v16 && k < elat + 4) begin
         @(negedge clk);
         k++;
      end
      check({name, "/latency"}, 32'(k), 32'(elat));
      check({name, "/result"}, 32'(r16), 32'(eres));
      check({name, "/zero"}, 32'(z16), 32'(eres == 16'h0));
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [5:0]  pool[8];
      logic [2:0]  mc;
      logic [31:0] mr, ra, rb;
      logic [1:0]  rop;
      logic [5:0]  rfn;
      logic [15:0] x, y, p;
      logic        mi;
      int          ml, k, nv, first;
      logic [31:0] res_at;

      rst = 1'b1; start = 1'b0; alu_op = 2'b00; funct = 6'h0; data1 = '0; data2 = '0;
      s16 = 1'b0; op16 = 2'b00; fn16 = 6'h0; a16 = '0; b16 = '0;
      repeat (2) @(negedge clk);
      check("reset/result", result, 32'h0);
      check("reset/zero", 32'(zero), 32'h1);
      check("reset/valid", 32'(valid), 32'h0);
      check("reset/busy", 32'(busy), 32'h0);
      check("reset/illegal", 32'(illegal), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      vecs[0]  = '{2'b11, 6'b101010, 32'hFFFF_FFFF, 32'h1, 3'b111, 32'h1, 1'b0, 1};
      vecs[1]  = '{2'b01, 6'b000000, 32'h5, 32'h5, 3'b110, 32'h0, 1'b0, 1};
      vecs[2]  = '{2'b11, 6'b111111, 32'h12, 32'h34, 3'b010, 32'h0, 1'b1, 1};
      vecs[3]  = '{2'b00, 6'b111111, 32'hFFFF_FFFF, 32'h1, 3'b010, 32'h0, 1'b0, 1};
      vecs[4]  = '{2'b11, 6'b011000, 32'h7, 32'h6, 3'b011, 32'd42, 1'b0, 33};
      vecs[5]  = '{2'b11, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000, 32'h00F0_1234, 1'b0, 1};
      vecs[6]  = '{2'b10, 6'b011000, 32'h0000_1200, 32'h0000_0034, 3'b001, 32'h0000_1234, 1'b0, 1};
      vecs[7]  = '{2'b11, 6'b101010, 32'h5, 32'hFFFF_FFFD, 3'b111, 32'h0, 1'b0, 1};
      vecs[8]  = '{2'b11, 6'b100000, 32'h3, 32'h4, 3'b010, 32'h7, 1'b0, 1};
      vecs[9]  = '{2'b01, 6'b100100, 32'h0, 32'h1, 3'b110, 32'hFFFF_FFFF, 1'b0, 1};
      vecs[10] = '{2'b11, 6'b100010, 32'd10, 32'd3, 3'b110, 32'h7, 1'b0, 1};
      vecs[11] = '{2'b11, 6'b011000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 32'h1, 1'b0, 33};
      vecs[12] = '{2'b11, 6'b011000, 32'h0001_0000, 32'h0001_0000, 3'b011, 32'h0, 1'b0, 33};
      vecs[13] = '{2'b11, 6'b100101, 32'hA5A5_0000, 32'h0000_5A5A, 3'b001, 32'hA5A5_5A5A, 1'b0, 1};
`ifdef ALU_MULTICYCLE_DIV_EN
      vecs[14] = '{2'b11, 6'b011010, 32'hFFFF_FFF9, 32'h2, 3'b100, 32'hFFFF_FFFD, 1'b0, 33};
      vecs[15] = '{2'b11, 6'b011010, 32'h9, 32'h0, 3'b100, 32'hFFFF_FFFF, 1'b0, 33};
`else
      vecs[14] = '{2'b11, 6'b011010, 32'hFFFF_FFF9, 32'h2, 3'b010, 32'h0, 1'b1, 1};
      vecs[15] = '{2'b11, 6'b011010, 32'h9, 32'h0, 3'b010, 32'h0, 1'b1, 1};
`endif
      for (int i = 0; i < 16; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b,
                vecs[i].ctrl, vecs[i].res, vecs[i].ill, vecs[i].lat);
      end

      // Reset in the middle of a MUL: async clear, no completion afterwards
      run_op("pre_rst_add", 2'b00, 6'h0, 32'h3, 32'h4, 3'b010, 32'h7, 1'b0, 1);
      alu_op = 2'b11; funct = 6'b011000; data1 = 32'd7; data2 = 32'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("rst_mid/busy_before", 32'(busy), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid/busy", 32'(busy), 32'h0);
      check("rst_mid/result", result, 32'h0);
      check("rst_mid/zero", 32'(zero), 32'h1);
      check("rst_mid/valid", 32'(valid), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      nv = 0;
      repeat (40) begin
         @(negedge clk);
         if (valid) nv++;
      end
      check("rst_mid/no_valid", 32'(nv), 32'h0);
      check("rst_mid/idle", 32'(busy), 32'h0);

      // start_i held high through a MUL; operands zeroed so a re-accept would show
      alu_op = 2'b11; funct = 6'b011000; data1 = 32'd7; data2 = 32'd6; start = 1'b1;
      @(negedge clk);
      data1 = 32'h0; data2 = 32'h0;
      nv = 0; first = 0; res_at = 32'h0;
      for (int c = 1; c <= 40; c++) begin
         if (valid) begin
            nv++;
            if (first == 0) begin
               first  = c;
               res_at = result;
            end
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("hold/valid_count", 32'(nv), 32'h1);
      check("hold/latency", 32'(first), 32'd33);
      check("hold/result", res_at, 32'd42);

      // Back-to-back: ADD issued in the DONE cycle, then MUL issued in DONE
      alu_op = 2'b11; funct = 6'b011000; data1 = 32'd7; data2 = 32'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_valid(40, k);
      check("b2b/mul_latency", 32'(k), 32'd33);
      check("b2b/mul_result", result, 32'd42);
      alu_op = 2'b00; data1 = 32'd3; data2 = 32'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b/add_valid", 32'(valid), 32'h1);
      check("b2b/add_result", result, 32'd7);
      check("b2b/add_busy", 32'(busy), 32'h0);
      alu_op = 2'b11; funct = 6'b011000; data1 = 32'd5; data2 = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_valid(40, k);
      alu_op = 2'b11; funct = 6'b011000; data1 = 32'd9; data2 = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b/mul_again_busy", 32'(busy), 32'h1);
      wait_valid(40, k);
      check("b2b/mul_again_latency", 32'(k), 32'd33);
      check("b2b/mul_again_result", result, 32'd81);
      @(negedge clk);

      // Randomised ops against the model
      pool[0] = 6'b100000; pool[1] = 6'b100010; pool[2] = 6'b100100; pool[3] = 6'b100101;
      pool[4] = 6'b101010; pool[5] = 6'b011000; pool[6] = 6'b011010; pool[7] = 6'b000000;
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         rfn = pool[$urandom_range(0, 7)];
         if (rfn == 6'b000000) rfn = 6'($urandom);
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 3);
         if ($urandom_range(0, 5) == 0) rb = ra;
         model(rop, rfn, ra, rb, mc, mr, mi, ml);
         run_op($sformatf("rnd%0d", i), rop, rfn, ra, rb, mc, mr, mi, ml);
      end

      // WIDTH=16, MUL_BITS=4 instance
      run16("w16/ffff_sq", 2'b11, 6'b011000, 16'hFFFF, 16'hFFFF, 16'h0001, 5);
      run16("w16/add_wrap", 2'b00, 6'h0, 16'hFFFF, 16'h0001, 16'h0000, 1);
      for (int i = 0; i < 8; i++) begin
         x = 16'($urandom);
         y = 16'($urandom);
         p = x * y;
         run16($sformatf("w16/rnd%0d", i), 2'b11, 6'b011000, x, y, p, 5);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
